vx_operand_collector: RTL and testbench



---
 rtl/vx_operand_collector.sv | 156 +++++++++++++++
 tb/tb_vx_operand_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_operand_collector.sv
// Multi-bank operand collector: gathers up to three source operands from a banked GPR file
// without bank conflicts. Optional macro VX_OPC_ZERO_REG_EN treats register r0 as an unused operand.
module vx_operand_collector #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int WIS_W       = 2,
  parameter int NUM_BANKS   = 2,
  parameter int META_W      = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIS_W-1:0]                        in_wis,
  input  logic [2:0]                              in_rs_used,
  input  logic [NR_BITS-1:0]                      in_rs1,
  input  logic [NR_BITS-1:0]                      in_rs2,
  input  logic [NR_BITS-1:0]                      in_rs3,
  input  logic [META_W-1:0]                       in_meta,
  output logic [NUM_BANKS-1:0]                    gpr_req_valid,
  output logic [NUM_BANKS*(WIS_W+NR_BITS)-1:0]    gpr_req_addr,
  input  logic [NUM_BANKS*NUM_THREADS*XLEN-1:0]   gpr_rsp_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [META_W-1:0]                       out_meta,
  output logic [NUM_THREADS*XLEN-1:0]             out_rs1_data,
  output logic [NUM_THREADS*XLEN-1:0]             out_rs2_data,
  output logic [NUM_THREADS*XLEN-1:0]             out_rs3_data
);
  localparam int AW = WIS_W + NR_BITS;
  localparam int DW = NUM_THREADS * XLEN;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
  state_t state, state_nx;

  logic [WIS_W-1:0]              wis_q;
  logic [2:0][NR_BITS-1:0]       rs_q;
  logic [2:0]                    pending_q;
  logic [META_W-1:0]             meta_q;
  logic [2:0][DW-1:0]            data_q;
  logic [NUM_BANKS-1:0]          tag_valid_q;
  logic [NUM_BANKS*2-1:0]        tag_q;
  logic [NUM_BANKS*2-1:0]        req_tag;
  logic [2:0]                    grant;
  logic [2:0]                    in_need;
  logic                          accept;

  function automatic logic [BW-1:0] bank_of(input logic [NR_BITS-1:0] rs);
    if (NUM_BANKS == 1) return '0;
    else return rs[BW-1:0];
  endfunction

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and the payload is held stable while valid waits.
  assign accept = in_valid && in_ready;

  always_comb begin
    in_need = in_rs_used;
`ifdef VX_OPC_ZERO_REG_EN
    if (in_rs1 == '0) in_need[0] = 1'b0;
    if (in_rs2 == '0) in_need[1] = 1'b0;
    if (in_rs3 == '0) in_need[2] = 1'b0;
`endif
  end

  // Lowest-numbered pending operand wins each bank, so per-bank reads retire in rs1>rs2>rs3 order.
  always_comb begin
    logic [NUM_BANKS-1:0] taken;
    logic [BW-1:0]        bank;
    taken         = '0;
    bank          = '0;
    grant         = '0;
    req_tag       = '0;
    gpr_req_valid = '0;
    gpr_req_addr  = '0;
    if (state == FETCH) begin
      for (int i = 0; i < 3; i++) begin
        bank = bank_of(rs_q[i]);
        if (pending_q[i] && !taken[bank]) begin
          taken[bank]                         = 1'b1;
          grant[i]                            = 1'b1;
          gpr_req_valid[bank]                 = 1'b1;
          gpr_req_addr[int'(bank)*AW +: AW]   = {wis_q, rs_q[i]};
          req_tag[int'(bank)*2 +: 2]          = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (in_need == 3'b0) ? OUT : FETCH;
      FETCH:   if ((pending_q & ~grant) == 3'b0) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT: begin
        if (out_ready) begin
          if (in_valid) state_nx = (in_need == 3'b0) ? OUT : FETCH;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == OUT);
    in_ready  = (state == IDLE) || ((state == OUT) && out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wis_q       <= '0;
      rs_q        <= '0;
      pending_q   <= '0;
      meta_q      <= '0;
      data_q      <= '0;
      tag_valid_q <= '0;
      tag_q       <= '0;
    end else begin
      tag_valid_q <= gpr_req_valid;
      tag_q       <= req_tag;
      if (state == FETCH) pending_q <= pending_q & ~grant;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (tag_valid_q[b]) begin
          case (tag_q[b*2 +: 2])
            2'd0:    data_q[0] <= gpr_rsp_data[b*DW +: DW];
            2'd1:    data_q[1] <= gpr_rsp_data[b*DW +: DW];
            default: data_q[2] <= gpr_rsp_data[b*DW +: DW];
          endcase
        end
      end
      // Accept only happens in IDLE/OUT, where no responses are in flight.
      if (accept) begin
        wis_q     <= in_wis;
        rs_q      <= {in_rs3, in_rs2, in_rs1};
        meta_q    <= in_meta;
        pending_q <= in_need;
        data_q    <= '0;
      end
    end
  end

  assign out_meta     = meta_q;
  assign out_rs1_data = data_q[0];
  assign out_rs2_data = data_q[1];
  assign out_rs3_data = data_q[2];

endmodule

// File: tb/tb_vx_operand_collector.sv
// Directed bench for vx_operand_collector with a per-bank schedule model and a GPR memory responder.
module tb_vx_operand_collector;
  localparam int NT = 4, XL = 32, NRB = 6, WW = 2, NB = 2, MW = 64;
  localparam int DW = NT * XL;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [WW-1:0]   in_wis;
  logic [2:0]      in_rs_used;
  logic [NRB-1:0]  in_rs1, in_rs2, in_rs3;
  logic [MW-1:0]   in_meta;
  logic [NB-1:0]   gpr_req_valid;
  logic [NB*8-1:0] gpr_req_addr;
  logic [NB*DW-1:0] gpr_rsp_data = '0;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   out_meta;
  logic [DW-1:0]   out_rs1_data, out_rs2_data, out_rs3_data;

  vx_operand_collector #(.NUM_THREADS(NT), .XLEN(XL), .NR_BITS(NRB), .WIS_W(WW),
                         .NUM_BANKS(NB), .META_W(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis),
    .in_rs_used(in_rs_used), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_meta(in_meta), .gpr_req_valid(gpr_req_valid), .gpr_req_addr(gpr_req_addr),
    .gpr_rsp_data(gpr_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_meta(out_meta), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs3_data(out_rs3_data)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int req_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // GPR contents: each lane encodes its {wis,rs} address and lane number
  function automatic logic [127:0] gpr_val(input logic [7:0] a);
    logic [127:0] v;
    logic [7:0]   t;
    v = '0;
    for (int l = 0; l < 4; l++) begin
      t = a * 8'd3 + 8'(l);
      v[l*32 +: 32] = {a, 8'(l), 8'hA5, t};
    end
    return v;
  endfunction

  // GPR responder: data for a request appears in the following cycle
  logic [NB*DW-1:0] rsp_pend;
  always @(negedge clk) begin
    rsp_pend = '0;
    for (int b = 0; b < NB; b++)
      if (gpr_req_valid[b]) rsp_pend[b*DW +: DW] = gpr_val(gpr_req_addr[b*8 +: 8]);
  end
  always @(posedge clk) gpr_rsp_data <= rsp_pend;

  // model state: expected requests {cycle, bank, addr}, current bundle, and when it appears
  logic [25:0]    exp_q[$];
  logic           busy_m = 1'b0;
  int             out_cyc = 0;
  logic [MW-1:0]  exp_meta;
  logic [DW-1:0]  exp_d [3];

  // scoreboard / compare process
  always @(negedge clk) begin : compare
    logic       exp_ov, exp_ir, found;
    logic [2:0] need;
    logic [5:0] rs [3];
    int         cnt [2];
    int         k, j;
    logic [7:0] ad;
    if (reset) begin
      busy_m = 1'b0;
      exp_q.delete();
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_req_valid", 128'(gpr_req_valid), 128'(0));
      chk("reset_in_ready", 128'(in_ready), 128'(1));
    end else begin
      exp_ov = busy_m && (cyc >= out_cyc);
      exp_ir = !busy_m || (exp_ov && out_ready);
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      chk("in_ready", 128'(in_ready), 128'(exp_ir));
      if (exp_ov) begin
        chk("out_meta", 128'(out_meta), 128'(exp_meta));
        chk("out_rs1_data", out_rs1_data, exp_d[0]);
        chk("out_rs2_data", out_rs2_data, exp_d[1]);
        chk("out_rs3_data", out_rs3_data, exp_d[2]);
      end
      for (int b = 0; b < NB; b++) begin
        if (gpr_req_valid[b]) begin
          req_seen++;
          found = 1'b0;
          ad = gpr_req_addr[b*8 +: 8];
          for (int q = 0; q < exp_q.size(); q++) begin
            if (exp_q[q] == {16'(cyc), 2'(b), ad}) begin
              exp_q.delete(q);
              found = 1'b1;
              break;
            end
          end
          checks++;
          if (!found) begin
            errors++;
            $display("FAIL gpr_req: unexpected read bank %0d addr %h at cycle %0d", b, ad, cyc);
          end
        end
      end
      j = 0;
      while (j < exp_q.size()) begin
        if (exp_q[j][25:10] <= 16'(cyc)) begin
          checks++;
          errors++;
          $display("FAIL gpr_req: missing read bank %0d addr %h due cycle %0d, now %0d",
                   exp_q[j][9:8], exp_q[j][7:0], exp_q[j][25:10], cyc);
          exp_q.delete(j);
        end else j++;
      end
      if (exp_ov && out_ready) busy_m = 1'b0;
      if (in_valid && exp_ir) begin
        need  = in_rs_used;
        rs[0] = in_rs1; rs[1] = in_rs2; rs[2] = in_rs3;
`ifdef VX_OPC_ZERO_REG_EN
        for (int i = 0; i < 3; i++) if (rs[i] == 6'd0) need[i] = 1'b0;
`endif
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 3; i++) begin
          ad = {in_wis, rs[i]};
          if (need[i]) begin
            cnt[rs[i][0]]++;
            exp_q.push_back({16'(cyc + cnt[rs[i][0]]), 2'(rs[i][0]), ad});
            exp_d[i] = gpr_val(ad);
          end else exp_d[i] = '0;
        end
        k = (cnt[0] > cnt[1]) ? cnt[0] : cnt[1];
        out_cyc  = cyc + ((k == 0) ? 1 : k + 2);
        exp_meta = in_meta;
        busy_m   = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [1:0] w, input logic [2:0] u, input logic [5:0] a,
                      input logic [5:0] b, input logic [5:0] c, input logic [63:0] m,
                      output int acc);
    @(posedge clk); #1;
    in_wis = w; in_rs_used = u; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_meta = m;
    in_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("send_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int after, output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid && cyc > after) begin c = cyc; break; end
    end
    if (c < 0) chk("out_timeout", 128'(0), 128'(1));
  endtask

  int ta, tb, to, r0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_wis = '0; in_rs_used = '0;
    in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_meta = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // three operands, bank0 twice: k=2
    r0 = req_seen;
    send(2'd1, 3'b111, 6'd4, 6'd6, 6'd5, 64'h1111_2222_3333_4444, ta);
    wait_out(ta, to);
    chk("t1_latency", 128'(to - ta), 128'(4));
    chk("t1_rs1_lane0", 128'(out_rs1_data[31:0]), 128'(32'h4400A5CC));
    chk("t1_rs3_lane0", 128'(out_rs3_data[31:0]), 128'(32'h4500A5CF));
    chk("t1_meta", 128'(out_meta), 128'(64'h1111_2222_3333_4444));
    chk("t1_reads", 128'(req_seen - r0), 128'(3));
    repeat (3) @(posedge clk);

    // no operands used
    r0 = req_seen;
    send(2'd2, 3'b000, 6'd9, 6'd10, 6'd11, 64'hDEAD_BEEF_0000_0001, ta);
    wait_out(ta, to);
    chk("t2_latency", 128'(to - ta), 128'(1));
    chk("t2_rs1_zero", 128'(out_rs1_data), 128'(0));
    chk("t2_meta", 128'(out_meta), 128'(64'hDEAD_BEEF_0000_0001));
    chk("t2_reads", 128'(req_seen - r0), 128'(0));
    repeat (3) @(posedge clk);

    // output stall with a spurious in_valid pulse
    out_ready = 1'b0;
    send(2'd2, 3'b101, 6'd2, 6'd3, 6'd7, 64'h0000_5555_AAAA_0000, ta);
    wait_out(ta, to);
    chk("t3_latency", 128'(to - ta), 128'(3));
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      in_valid = (s == 2);
      in_rs_used = 3'b111; in_rs1 = 6'd1; in_meta = 64'hBAD;
      @(negedge clk);
      chk("t3_stall_in_ready", 128'(in_ready), 128'(0));
      chk("t3_stall_out_valid", 128'(out_valid), 128'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_in_ready", 128'(in_ready), 128'(1));
    repeat (3) @(posedge clk);

    // back-to-back: B accepted in A's output cycle; B reads r8 twice
    send(2'd0, 3'b001, 6'd3, 6'd0, 6'd0, 64'hA, ta);
    send(2'd0, 3'b011, 6'd8, 6'd8, 6'd1, 64'hB, tb);
    chk("t4_no_bubble", 128'(tb - ta), 128'(3));
    wait_out(tb, to);
    chk("t4_b_latency", 128'(to - tb), 128'(4));
    chk("t4_b_rs2_lane1", 128'(out_rs2_data[63:32]), 128'(32'h0801A519));
    repeat (3) @(posedge clk);

    // reset during FETCH
    send(2'd1, 3'b111, 6'd4, 6'd6, 6'd5, 64'hFEED, ta);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
    chk("t5_rst_req_valid", 128'(gpr_req_valid), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", 128'(in_ready), 128'(1));
    send(2'd3, 3'b011, 6'd1, 6'd3, 6'd0, 64'hC0FFEE, ta);
    wait_out(ta, to);
    chk("t5_latency", 128'(to - ta), 128'(4));
    repeat (3) @(posedge clk);

    // register zero as a source
    r0 = req_seen;
    send(2'd0, 3'b111, 6'd0, 6'd2, 6'd4, 64'h7, ta);
    wait_out(ta, to);
`ifdef VX_OPC_ZERO_REG_EN
    chk("t6_latency", 128'(to - ta), 128'(4));
    chk("t6_reads", 128'(req_seen - r0), 128'(2));
    chk("t6_rs1_lane0", 128'(out_rs1_data[31:0]), 128'(0));
`else
    chk("t6_latency", 128'(to - ta), 128'(5));
    chk("t6_reads", 128'(req_seen - r0), 128'(3));
    chk("t6_rs1_lane0", 128'(out_rs1_data[31:0]), 128'(32'h0000A500));
`endif
    repeat (5) @(posedge clk);

    chk("leftover_reads", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
